// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: drives the ALU's button/wren/dataIn command port from
// a valid/ready request stream. Each accepted command becomes one timed,
// active-low button press. wren and dataIn stay stable for the whole press.
// A read samples RESULT and the flags after the press and returns them on a
// response handshake.
// Optional macro ALU_SEQ_RETRY_EN: a blocked command (write while the ALU
// FIFO is full, or read while it is empty) parks in WAIT until it can run.
// Without the macro, such a command is rejected with a one-cycle cmd_err.
module alu_cmd_sequencer #(
    parameter int HOLD_CYCLES   = 4,
    parameter int GAP_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int DATA_W        = 15,
    parameter int RES_W         = 6
) (
    input  logic              clock,
    input  logic              reset,
    // Handshakes: a command transfers on a clock edge where cmd_valid and
    // cmd_ready are both high. A response transfers on an edge where
    // rsp_valid and rsp_ready are both high. The producer holds valid and
    // its payload stable until the transfer. cmd_ready never depends on
    // cmd_valid.
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              alu_wren,
    output logic              alu_button,
    output logic [DATA_W-1:0] alu_data,
    input  logic              alu_full,
    input  logic              alu_empty,
    input  logic [RES_W-1:0]  alu_result,
    input  logic              alu_neg_result,
    input  logic              alu_overflow,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_result,
    output logic              rsp_neg,
    output logic              rsp_ovf,
    output logic              cmd_err,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_PRESS   = 3'd2,
        S_RELEASE = 3'd3,
        S_SETTLE  = 3'd4,
`ifdef ALU_SEQ_RETRY_EN
        S_RESP    = 3'd5,
        S_WAIT    = 3'd6
`else
        S_RESP    = 3'd5
`endif
    } state_t;

    // Each phase counter loads (length - 1) on entry, and the phase ends on
    // the edge where the counter reads zero.
    localparam logic [7:0] GAP_LOAD    = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                button_q, button_d;
    logic                wren_q, wren_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [RES_W-1:0]    rsp_result_q, rsp_result_d;
    logic                rsp_neg_q, rsp_neg_d;
    logic                rsp_ovf_q, rsp_ovf_d;
    logic                cmd_err_q, cmd_err_d;
    logic                blocked;

    // The command is blocked when the ALU FIFO cannot take or give the item.
    assign blocked = cmd_write ? alu_full : alu_empty;

    // Next-state and registered-output logic for the press schedule.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        button_d     = button_q;
        wren_d       = wren_q;
        data_d       = data_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_neg_d    = rsp_neg_q;
        rsp_ovf_d    = rsp_ovf_q;
        cmd_err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Reset has priority in the register block, so cmd_ready
                // reduces to the IDLE state here.
                if (cmd_valid) begin
                    if (blocked) begin
`ifdef ALU_SEQ_RETRY_EN
                        wren_d  = cmd_write;
                        if (cmd_write) data_d = cmd_data;
                        state_d = S_WAIT;
`else
                        cmd_err_d = 1'b1;
`endif
                    end else begin
                        wren_d  = cmd_write;
                        if (cmd_write) data_d = cmd_data;
                        state_d = S_SETUP;
                        cnt_d   = GAP_LOAD;
                    end
                end
            end
`ifdef ALU_SEQ_RETRY_EN
            S_WAIT: begin
                if (!(wren_q ? alu_full : alu_empty)) begin
                    state_d = S_SETUP;
                    cnt_d   = GAP_LOAD;
                end
            end
`endif
            S_SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d  = S_PRESS;
                    cnt_d    = HOLD_LOAD;
                    button_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_PRESS: begin
                if (cnt_q == 8'd0) begin
                    state_d  = S_RELEASE;
                    cnt_d    = GAP_LOAD;
                    button_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RELEASE: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    cnt_d = 8'd0;
                    if (wren_q) begin
                        state_d = S_IDLE;
                    end else begin
                        rsp_result_d = alu_result;
                        rsp_neg_d    = alu_neg_result;
                        rsp_ovf_d    = alu_overflow;
                        rsp_valid_d  = 1'b1;
                        state_d      = S_RESP;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                cnt_d    = 8'd0;
                button_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            button_q     <= 1'b1;
            wren_q       <= 1'b0;
            data_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_neg_q    <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            button_q     <= button_d;
            wren_q       <= wren_d;
            data_q       <= data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_neg_q    <= rsp_neg_d;
            rsp_ovf_q    <= rsp_ovf_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE) && !reset;
    assign busy       = (state_q != S_IDLE);
    assign dbg_state  = state_q;
    assign alu_button = button_q;
    assign alu_wren   = wren_q;
    assign alu_data   = data_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_neg    = rsp_neg_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed timing scenarios plus an ALU FIFO
// stub, with read responses checked against an expected queue.
module tb_alu_cmd_sequencer;

    localparam int GAP = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [14:0] cmd_data = '0;
    logic        alu_wren;
    logic        alu_button;
    logic [14:0] alu_data;
    logic        alu_full;
    logic        alu_empty;
    logic [5:0]  alu_result;
    logic        alu_neg_result;
    logic        alu_overflow;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [5:0]  rsp_result;
    logic        rsp_neg;
    logic        rsp_ovf;
    logic        cmd_err;
    logic        busy;
    logic [2:0]  dbg_state;

    // Directed ALU inputs and FIFO-stub inputs, selected by model_en.
    logic        model_en = 1'b0;
    logic        d_full = 1'b0, d_empty = 1'b0, d_neg = 1'b0, d_ovf = 1'b0;
    logic [5:0]  d_result = '0;
    logic        m_full = 1'b0, m_empty = 1'b1, m_neg = 1'b0, m_ovf = 1'b0;
    logic [5:0]  m_result = '0;
    logic [14:0] fifo_q[$];

    assign alu_full       = model_en ? m_full   : d_full;
    assign alu_empty      = model_en ? m_empty  : d_empty;
    assign alu_result     = model_en ? m_result : d_result;
    assign alu_neg_result = model_en ? m_neg    : d_neg;
    assign alu_overflow   = model_en ? m_ovf    : d_ovf;

    int n_checks = 0;
    int n_fail = 0;
    int press_cnt = 0;
    int rise_cnt = 0;
    int err_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_v;
    logic [14:0] pop_v;
    logic        prev_btn = 1'b1;
    logic        hold_wren = 1'b0;
    logic [14:0] hold_data = '0;

    alu_cmd_sequencer dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_data(cmd_data),
        .alu_wren(alu_wren), .alu_button(alu_button), .alu_data(alu_data),
        .alu_full(alu_full), .alu_empty(alu_empty),
        .alu_result(alu_result), .alu_neg_result(alu_neg_result),
        .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_neg(rsp_neg), .rsp_ovf(rsp_ovf),
        .cmd_err(cmd_err), .busy(busy), .dbg_state(dbg_state)
    );

    // Clock and watchdog.
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives one command and returns just after its accept edge.
    task automatic send_cmd(input logic w, input logic [14:0] d);
        int ok;
        ok = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_data  = d;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin
                tick();
                ok = 1;
                break;
            end
            tick();
        end
        cmd_valid = 1'b0;
        if (ok == 0) check("cmd_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) break;
            tick();
        end
        check(tag, cmd_ready, 1);
    endtask

    // Write with the full cycle-by-cycle button timeline checked.
    task automatic run_write_timeline(input logic [14:0] d);
        logic [14:0] btn_vec, exp_vec;
        logic        saw_rsp;
        send_cmd(1'b1, d);
        btn_vec = '0;
        exp_vec = '0;
        saw_rsp = 1'b0;
        btn_vec[0] = alu_button;
        exp_vec[0] = 1'b1;
        check("wr_wren_e0", alu_wren, 1);
        check("wr_data_e0", alu_data, d);
        check("wr_busy_e0", busy, 1);
        for (int n = 1; n <= 14; n++) begin
            if (n == 14) check("wr_ready_e13", cmd_ready, 0);
            tick();
            btn_vec[n] = alu_button;
            exp_vec[n] = (n >= 4 && n <= 7) ? 1'b0 : 1'b1;
            saw_rsp = saw_rsp | rsp_valid;
        end
        check("wr_button_timeline", btn_vec, exp_vec);
        check("wr_ready_e14", cmd_ready, 1);
        check("wr_busy_e14", busy, 0);
        check("wr_no_rsp", saw_rsp, 0);
        check("wr_wren_held", alu_wren, 1);
        check("wr_data_held", alu_data, d);
    endtask

    // Monitor on the falling edge: response scoreboard, press accounting,
    // stability of wren/data while pressed, and the ALU FIFO stub.
    always @(negedge clock) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                exp_v = exp_q.pop_front();
                check("rsp_data", {rsp_ovf, rsp_neg, rsp_result}, exp_v);
            end
        end
        if (cmd_err) err_cnt++;
        if (prev_btn && !alu_button) begin
            press_cnt++;
            hold_wren = alu_wren;
            hold_data = alu_data;
            if (model_en) begin
                if (alu_wren) begin
                    fifo_q.push_back(alu_data);
                end else if (fifo_q.size() > 0) begin
                    pop_v    = fifo_q.pop_front();
                    m_result = pop_v[11:6] ^ pop_v[5:0];
                    m_neg    = pop_v[14];
                    m_ovf    = pop_v[13];
                end
                m_full  = (fifo_q.size() == 8);
                m_empty = (fifo_q.size() == 0);
            end
        end else if (!prev_btn && !alu_button) begin
            check("press_wren_stable", alu_wren, hold_wren);
            check("press_data_stable", alu_data, hold_data);
        end
        if (!prev_btn && alu_button) rise_cnt++;
        prev_btn = alu_button;
    end

    initial begin
        int p0, e0, r0, cnt;
        logic [14:0] d;

        // Reset held two cycles.
        reset = 1'b1;
        tick();
        tick();
        check("rst_ready", cmd_ready, 0);
        check("rst_button", alu_button, 1);
        check("rst_wren", alu_wren, 0);
        check("rst_data", alu_data, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", cmd_err, 0);
        reset = 1'b0;
        #1;
        check("rst_ready_after", cmd_ready, 1);

        // Directed write.
        p0 = press_cnt;
        run_write_timeline(15'h1234);
        check("wr_one_press", press_cnt - p0, 1);

        // Directed read with a held-off response.
        d_empty  = 1'b0;
        d_result = 6'b111101;
        d_neg    = 1'b1;
        d_ovf    = 1'b0;
        exp_q.push_back(8'h7D);
        rsp_ready = 1'b0;
        send_cmd(1'b0, 15'h7FFF);
        check("rd_wren", alu_wren, 0);
        check("rd_data_kept", alu_data, 15'h1234);
        for (int n = 1; n <= 14; n++) begin
            if (n == 14) check("rd_valid_e13", rsp_valid, 0);
            tick();
        end
        check("rd_valid_e14", rsp_valid, 1);
        check("rd_result", rsp_result, 6'h3D);
        check("rd_neg", rsp_neg, 1);
        check("rd_ovf", rsp_ovf, 0);
        d_result = 6'h05;
        d_neg    = 1'b0;
        d_ovf    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rd_hold_valid", rsp_valid, 1);
            check("rd_hold_result", rsp_result, 6'h3D);
            check("rd_hold_flags", {rsp_neg, rsp_ovf}, 2'b10);
            check("rd_hold_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rd_valid_drop", rsp_valid, 0);
        check("rd_ready_back", cmd_ready, 1);
        check("rd_result_kept", rsp_result, 6'h3D);

        // Blocked write.
        p0 = press_cnt;
        e0 = err_cnt;
        d_full = 1'b1;
`ifdef ALU_SEQ_RETRY_EN
        send_cmd(1'b1, 15'h0F0F);
        check("retry_no_err", cmd_err, 0);
        check("retry_busy", busy, 1);
        for (int i = 0; i < 3; i++) tick();
        check("retry_wait_button", alu_button, 1);
        check("retry_wait_busy", busy, 1);
        d_full = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cnt++;
            if (!alu_button) break;
        end
        check("retry_press_delay", cnt, GAP + 1);
        wait_idle("retry_idle");
        check("retry_one_press", press_cnt - p0, 1);
        check("retry_err_cnt", err_cnt - e0, 0);
`else
        send_cmd(1'b1, 15'h0F0F);
        check("rej_wr_err_e0", cmd_err, 1);
        check("rej_wr_ready", cmd_ready, 1);
        tick();
        check("rej_wr_err_e1", cmd_err, 0);
        d_full = 1'b0;
        d_empty = 1'b1;
        send_cmd(1'b0, 15'h0);
        check("rej_rd_err_e0", cmd_err, 1);
        for (int i = 0; i < 4; i++) tick();
        d_empty = 1'b0;
        check("rej_ready", cmd_ready, 1);
        check("rej_busy", busy, 0);
        check("rej_no_press", press_cnt - p0, 0);
        check("rej_err_cnt", err_cnt - e0, 2);
        check("rej_no_rsp", rsp_valid, 0);
`endif

        // Reset during the second press cycle.
        e0 = err_cnt;
        send_cmd(1'b1, 15'h0ABC);
        for (int i = 0; i < 5; i++) tick();
        check("mid_pressed", alu_button, 0);
        reset = 1'b1;
        tick();
        check("mid_button", alu_button, 1);
        check("mid_wren", alu_wren, 0);
        check("mid_busy", busy, 0);
        check("mid_rsp_valid", rsp_valid, 0);
        reset = 1'b0;
        #1;
        check("mid_no_err", err_cnt - e0, 0);
        run_write_timeline(15'h2A55);

        // Back-to-back traffic against the ALU FIFO stub.
        fifo_q.delete();
        m_full   = 1'b0;
        m_empty  = 1'b1;
        model_en = 1'b1;
        rsp_ready = 1'b1;
        p0 = press_cnt;
        r0 = rise_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 8; i++) begin
            d = 15'($urandom_range(0, 32767));
            exp_q.push_back({d[13], d[14], d[11:6] ^ d[5:0]});
            send_cmd(1'b1, d);
        end
        for (int i = 0; i < 8; i++) send_cmd(1'b0, 15'h0);
        wait_idle("fifo_idle");
        tick();
        check("fifo_presses", press_cnt - p0, 16);
        check("fifo_releases", rise_cnt - r0, 16);
        check("fifo_no_err", err_cnt - e0, 0);
        check("fifo_exp_drained", exp_q.size(), 0);
        rsp_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Host-side initiator for the ALU's button/wren/dataIn command interface.
- Accepts write (push 15-bit instruction) and read (pop result) requests on a valid/ready port. Converts each into a timed active-low button press with wren and data held stable.
- Honours the ALU FIFO full/empty flags.
- On reads, samples RESULT and flags after the press and returns them on a response handshake.
- Replaces manual pushbutton stimulus when the ALU is driven by an on-chip controller.

Parameters:
- HOLD_CYCLES, 4, cycles button is held low (1..255)
- GAP_CYCLES, 4, setup cycles before press and release cycles after press (1..255)
- SETTLE_CYCLES, 2, cycles after release before result sample/completion (1..255)
- DATA_W, 15, instruction width {control[14:12], A[11:6], B[5:0]}
- RES_W, 6, ALU result width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  sequencer can accept command
- cmd_write  in  1  1=write instruction, 0=read result
- cmd_data  in  DATA_W  instruction word (ignored on reads)
- alu_wren  out  1  to ALU wren
- alu_button  out  1  to ALU button, active-low
- alu_data  out  DATA_W  to ALU dataIn
- alu_full  in  1  ALU FIFO full
- alu_empty  in  1  ALU FIFO empty
- alu_result  in  RES_W  ALU RESULT
- alu_neg_result  in  1  ALU NEG_RESULT
- alu_overflow  in  1  ALU OVERFLOW_FLAG
- rsp_valid  out  1  read response available
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  RES_W  captured result
- rsp_neg  out  1  captured NEG_RESULT
- rsp_ovf  out  1  captured OVERFLOW_FLAG
- cmd_err  out  1  one-cycle pulse: command rejected (write when full / read when empty)
- busy  out  1  state != IDLE

Behaviour:
- Interface: one clock (clock); reset is synchronous, active-high.
- Reset (sampled at posedge):
  - state=IDLE; all counters=0.
  - alu_button=1, alu_wren=0, alu_data=0.
  - rsp_valid=0, rsp_result=0, rsp_neg=0, rsp_ovf=0, cmd_err=0.
  - cmd_ready=0 while reset high; busy=0.
- cmd_ready = (state==IDLE) && !reset.
- Accept edge E0 = posedge with cmd_valid && cmd_ready.
- Full/empty are sampled only at E0.
- At E0:
  - Write with alu_full=1, or read with alu_empty=1: cmd_err=1 for exactly one cycle, state stays IDLE, no press, no response.
  - Otherwise: latch alu_wren=cmd_write and alu_data=cmd_data (alu_data unchanged on reads); go to SETUP.
- States (all counter-timed; every output registered):
  - SETUP: button=1 for GAP_CYCLES.
  - PRESS: button=0 for HOLD_CYCLES; entered at E(GAP).
  - RELEASE: button=1 for GAP_CYCLES; entered at E(GAP+HOLD).
  - SETTLE: for SETTLE_CYCLES; entered at E(2*GAP+HOLD).
- At E(T), T = 2*GAP+HOLD+SETTLE (14 at defaults):
  - Write: go to IDLE; cmd_ready=1 from E(T).
  - Read: capture alu_result/alu_neg_result/alu_overflow into rsp_*; rsp_valid=1; go to RESP.
- RESP: hold rsp_* stable while rsp_ready=0. On posedge with rsp_valid && rsp_ready: rsp_valid=0, go to IDLE. rsp_* retain their last values.
- alu_wren/alu_data are held from E0 through IDLE return; they are never changed while button is low.
- Exactly one falling and one rising edge of alu_button per accepted command.
- Commands arriving outside IDLE are stalled (cmd_ready=0), never dropped.
- Reset mid-operation (any state):
  - Next edge forces IDLE, button=1, wren=0, rsp_valid=0.
  - A truncated press is permitted; no cmd_err.
- Counter is 8 bits, loads (param-1) on state entry, transitions at 0.

Optional Feature:
- Macro ALU_SEQ_RETRY_EN.
- Defined:
  - A blocked command (write with full / read with empty) is accepted into state WAIT; cmd_err is never asserted.
  - WAIT re-evaluates alu_full/alu_empty every cycle, proceeds to SETUP on the first cycle the condition is clear, and the normal schedule follows.
  - busy=1 in WAIT.
  - reset leaves WAIT.
- Undefined: reject-with-cmd_err behaviour as above; the WAIT state is not present.

Test Plan:
- Reset held 2 cycles -> alu_button=1, alu_wren=0, alu_data=0, rsp_valid=0, cmd_ready=0 during reset, cmd_ready=1 first cycle after.
- Write cmd_data=15'h1234, alu_full=0 ->
  - alu_wren=1 and alu_data=15'h1234 from E0.
  - alu_button low exactly cycles E4..E7 (4 cycles).
  - cmd_ready=1 at E14; rsp_valid never asserted.
- Read with alu_empty=0, alu_result=6'b111101, neg=1, ovf=0 ->
  - rsp_valid at E14, rsp_result=6'h3D, rsp_neg=1, rsp_ovf=0.
  - rsp_ready low 3 cycles keeps values stable.
  - rsp_ready=1 -> rsp_valid=0 next cycle, cmd_ready=1.
- Write with alu_full=1 (macro undefined) -> cmd_err high exactly 1 cycle, alu_button never low, cmd_ready stays 1. Same with ALU_SEQ_RETRY_EN -> no cmd_err; press starts GAP_CYCLES after alu_full falls.
- Reset asserted during 2nd PRESS cycle -> next edge alu_button=1, alu_wren=0, busy=0; following command runs full normal schedule.
- 8 back-to-back writes then 8 reads against an ALU FIFO model -> 16 presses total, responses returned in write order, no cmd_err, no overlapping presses.
